// File: rtl/dwrr_ingress_queues.sv
`default_nettype none
// ============================================================================
// Module      : dwrr_ingress_queues
// Description : Per-requestor packet FIFO bank feeding a DWRR arbiter.
//               Each source pushes into its own queue, and reqs[i] flags a
//               non-empty queue. A one-hot gnt pops one packet, which appears
//               on out_* one cycle later. An illegal gnt (multi-hot, or aimed
//               at an empty queue) pops nothing and sets the sticky err_pop.
//               Optional feature macro: DWRR_QUEUE_OCC_EN adds the occ port,
//               which exposes the per-queue occupancy counts.
// Revision    : 1.0 - initial release
// ============================================================================
module dwrr_ingress_queues #(
    parameter int NUM_REQS = 4,
    parameter int DWIDTH   = 32,
    parameter int DEPTH    = 8,
    parameter int CNTWID   = $clog2(NUM_REQS),
    parameter int PWID     = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQS-1:0]          in_valid,
    input  logic [NUM_REQS*DWIDTH-1:0]   in_data,
    output logic [NUM_REQS-1:0]          in_ready,
    output logic [NUM_REQS-1:0]          reqs,
    input  logic [NUM_REQS-1:0]          gnt,
    output logic                         out_valid,
    output logic [DWIDTH-1:0]            out_data,
    output logic [CNTWID-1:0]            out_src,
    output logic                         err_pop
`ifdef DWRR_QUEUE_OCC_EN
    ,
    output logic [NUM_REQS*(PWID+1)-1:0] occ
`endif
);

    localparam logic [PWID:0]   c_FULL_CNT = (PWID+1)'(DEPTH);
    localparam logic [PWID:0]   c_CNT_ONE  = (PWID+1)'(1);
    localparam logic [PWID-1:0] c_PTR_ONE  = PWID'(1);

    // Storage and per-queue registered state
    logic [DWIDTH-1:0] r_mem_q   [NUM_REQS][DEPTH];
    logic [PWID-1:0]   r_wptr_q  [NUM_REQS];
    logic [PWID-1:0]   w_wptr_d  [NUM_REQS];
    logic [PWID-1:0]   r_rptr_q  [NUM_REQS];
    logic [PWID-1:0]   w_rptr_d  [NUM_REQS];
    logic [PWID:0]     r_count_q [NUM_REQS];
    logic [PWID:0]     w_count_d [NUM_REQS];

    // Output registers
    logic              r_out_valid_q;
    logic              w_out_valid_d;
    logic [DWIDTH-1:0] r_out_data_q;
    logic [DWIDTH-1:0] w_out_data_d;
    logic [CNTWID-1:0] r_out_src_q;
    logic [CNTWID-1:0] w_out_src_d;
    logic              r_err_q;
    logic              w_err_d;

    // Handshake decode
    logic [NUM_REQS-1:0] w_push;
    logic [NUM_REQS-1:0] w_pop;
    logic                w_gnt_onehot;
    logic                w_pop_any;
    logic [CNTWID-1:0]   w_pop_idx;

    // Flags decode from registered counts only, so the arbiter loop through
    // reqs -> gnt stays free of combinational paths.
    generate
        for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_flags
            assign in_ready[gi] = (r_count_q[gi] != c_FULL_CNT);
            assign reqs[gi]     = (r_count_q[gi] != '0);
        end
    endgenerate

`ifdef DWRR_QUEUE_OCC_EN
    generate
        for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_occ
            assign occ[gi*(PWID+1) +: (PWID+1)] = r_count_q[gi];
        end
    endgenerate
`endif

    // Qualify pushes and the pop, and encode the popped queue's index.
    always_comb begin
        w_push       = in_valid & in_ready;
        w_gnt_onehot = (gnt != '0) && ((gnt & (gnt - NUM_REQS'(1))) == '0);
        w_pop        = w_gnt_onehot ? (gnt & reqs) : '0;
        w_pop_any    = |w_pop;
        w_pop_idx    = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (w_pop[i]) begin
                w_pop_idx = CNTWID'(i);
            end
        end
    end

    // Next pointers and counts. A simultaneous push and pop leaves the count
    // unchanged while both pointers advance.
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            w_wptr_d[i]  = r_wptr_q[i];
            w_rptr_d[i]  = r_rptr_q[i];
            w_count_d[i] = r_count_q[i];
            if (w_push[i]) begin
                w_wptr_d[i] = r_wptr_q[i] + c_PTR_ONE;
            end
            if (w_pop[i]) begin
                w_rptr_d[i] = r_rptr_q[i] + c_PTR_ONE;
            end
            case ({w_push[i], w_pop[i]})
                2'b10:   w_count_d[i] = r_count_q[i] + c_CNT_ONE;
                2'b01:   w_count_d[i] = r_count_q[i] - c_CNT_ONE;
                default: w_count_d[i] = r_count_q[i];
            endcase
        end
    end

    // Next output state. Data and source hold when there is no pop, and any
    // non-zero gnt that fails to pop latches the error.
    always_comb begin
        w_out_valid_d = w_pop_any;
        w_out_data_d  = r_out_data_q;
        w_out_src_d   = r_out_src_q;
        if (w_pop_any) begin
            w_out_data_d = r_mem_q[w_pop_idx][r_rptr_q[w_pop_idx]];
            w_out_src_d  = w_pop_idx;
        end
        w_err_d = r_err_q | ((gnt != '0) && !w_pop_any);
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                r_wptr_q[i]  <= '0;
                r_rptr_q[i]  <= '0;
                r_count_q[i] <= '0;
            end
            r_out_valid_q <= 1'b0;
            r_out_data_q  <= '0;
            r_out_src_q   <= '0;
            r_err_q       <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                r_wptr_q[i]  <= w_wptr_d[i];
                r_rptr_q[i]  <= w_rptr_d[i];
                r_count_q[i] <= w_count_d[i];
            end
            r_out_valid_q <= w_out_valid_d;
            r_out_data_q  <= w_out_data_d;
            r_out_src_q   <= w_out_src_d;
            r_err_q       <= w_err_d;
        end
    end

    // Packet storage. It is not reset, and writes are suppressed in the
    // reset cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQS; i++) begin
            if (!rst && w_push[i]) begin
                r_mem_q[i][r_wptr_q[i]] <= in_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    assign out_valid = r_out_valid_q;
    assign out_data  = r_out_data_q;
    assign out_src   = r_out_src_q;
    assign err_pop   = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dwrr_ingress_queues.sv
`default_nettype none
// ============================================================================
// Module      : tb_dwrr_ingress_queues
// Description : Self-checking bench for dwrr_ingress_queues. It runs directed
//               scenarios followed by randomized traffic. A queue-based
//               reference model supplies the expected value for every output
//               on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dwrr_ingress_queues;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int DP = 8;
    localparam int PW = 3;
    localparam int CW = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NR-1:0]       in_valid;
    logic [NR*DW-1:0]    in_data;
    logic [NR-1:0]       in_ready;
    logic [NR-1:0]       reqs;
    logic [NR-1:0]       gnt;
    logic                out_valid;
    logic [DW-1:0]       out_data;
    logic [CW-1:0]       out_src;
    logic                err_pop;
`ifdef DWRR_QUEUE_OCC_EN
    logic [NR*(PW+1)-1:0] occ;
`endif

    always #5 clk = ~clk;

    dwrr_ingress_queues #(
        .NUM_REQS (NR),
        .DWIDTH   (DW),
        .DEPTH    (DP),
        .CNTWID   (CW),
        .PWID     (PW)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .reqs      (reqs),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .err_pop   (err_pop)
`ifdef DWRR_QUEUE_OCC_EN
        ,
        .occ       (occ)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one FIFO per source plus the expected output registers
    logic [DW-1:0] mq [NR][$];
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic [CW-1:0] exp_src;
    logic          exp_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("reqs[%0d]", i), 64'(reqs[i]), 64'(mq[i].size() != 0));
            chk($sformatf("in_ready[%0d]", i), 64'(in_ready[i]), 64'(mq[i].size() != DP));
`ifdef DWRR_QUEUE_OCC_EN
            chk($sformatf("occ[%0d]", i), 64'(occ[i*(PW+1) +: (PW+1)]), 64'(mq[i].size()));
`endif
        end
        chk("out_valid", 64'(out_valid), 64'(exp_valid));
        chk("out_data", 64'(out_data), 64'(exp_data));
        chk("out_src", 64'(out_src), 64'(exp_src));
        chk("err_pop", 64'(err_pop), 64'(exp_err));
    endtask

    // Advance the model by one clock edge, given the inputs of that cycle.
    task automatic model_step(input logic [NR-1:0] v, input logic [NR*DW-1:0] d,
                              input logic [NR-1:0] g, input logic r);
        bit ready [NR];
        int idx;
        if (r) begin
            for (int i = 0; i < NR; i++) mq[i].delete();
            exp_valid = 1'b0;
            exp_data  = '0;
            exp_src   = '0;
            exp_err   = 1'b0;
        end else begin
            for (int i = 0; i < NR; i++) ready[i] = (mq[i].size() < DP);
            exp_valid = 1'b0;
            if (g != '0) begin
                idx = -1;
                if ($countones(g) == 1) begin
                    for (int i = 0; i < NR; i++) if (g[i]) idx = i;
                end
                if (idx >= 0 && mq[idx].size() > 0) begin
                    exp_valid = 1'b1;
                    exp_data  = mq[idx].pop_front();
                    exp_src   = CW'(idx);
                end else begin
                    exp_err = 1'b1;
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (v[i] && ready[i]) mq[i].push_back(d[i*DW +: DW]);
            end
        end
    endtask

    // One cycle: check the current outputs, then drive new inputs for the next edge.
    task automatic cycle(input logic [NR-1:0] v, input logic [NR*DW-1:0] d,
                         input logic [NR-1:0] g, input logic r);
        @(negedge clk);
        check_outputs();
        rst      = r;
        in_valid = v;
        in_data  = d;
        gnt      = g;
        model_step(v, d, g, r);
    endtask

    function automatic logic [NR*DW-1:0] pk(input int q, input logic [DW-1:0] val);
        logic [NR*DW-1:0] res;
        res = '0;
        res[q*DW +: DW] = val;
        return res;
    endfunction

    task automatic push1(input int q, input logic [DW-1:0] val, input logic [NR-1:0] g);
        cycle(NR'(1) << q, pk(q, val), g, 1'b0);
    endtask

    task automatic idle();
        cycle('0, '0, '0, 1'b0);
    endtask

    initial begin
        logic [NR*DW-1:0] rd;
        logic [NR-1:0]    rg;
        int               mode;

        rst      = 1'b1;
        in_valid = '0;
        in_data  = '0;
        gnt      = '0;
        for (int i = 0; i < NR; i++) mq[i].delete();
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_src   = '0;
        exp_err   = 1'b0;
        repeat (2) @(posedge clk);
        cycle('0, '0, '0, 1'b1);

        // Two packets into queue 2, then two grants
        push1(2, 32'hA0, '0);
        push1(2, 32'hA1, '0);
        cycle('0, '0, 4'b0100, 1'b0);
        cycle('0, '0, 4'b0100, 1'b0);
        idle();
        idle();

        // Fill queue 0, overflow attempt, push+pop while full, then drain
        for (int k = 0; k < DP; k++) push1(0, 32'hB0 + k, '0);
        push1(0, 32'hBF, '0);
        push1(0, 32'hC0, 4'b0001);
        idle();
        for (int k = 0; k < DP - 1; k++) cycle('0, '0, 4'b0001, 1'b0);
        idle();

        // Ten packets through queue 1 so that both pointers wrap
        push1(1, 32'hD0, '0);
        for (int k = 1; k < 10; k++) push1(1, 32'hD0 + k, 4'b0010);
        cycle('0, '0, 4'b0010, 1'b0);
        idle();

        // Multi-hot grant, then a grant to an empty queue
        cycle(4'b0011, {32'h0, 32'h0, 32'hE1, 32'hE0}, '0, 1'b0);
        cycle('0, '0, 4'b0011, 1'b0);
        idle();
        cycle('0, '0, 4'b1000, 1'b0);
        idle();
        cycle('0, '0, 4'b0001, 1'b0);
        cycle('0, '0, 4'b0010, 1'b0);
        idle();

        // Empty queue 3: plain push, then push and pop together
        push1(3, 32'hF0, '0);
        push1(3, 32'hF1, 4'b1000);
        idle();
        cycle('0, '0, 4'b1000, 1'b0);
        idle();

        // Reset in the middle of traffic, coinciding with a grant
        for (int k = 0; k < 3; k++) push1(0, 32'h50 + k, '0);
        cycle('0, '0, 4'b0001, 1'b1);
        idle();
        idle();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NR; i++) rd[i*DW +: DW] = $urandom;
            mode = int'($urandom_range(0, 9));
            if (mode <= 6)      rg = NR'(1) << $urandom_range(0, NR - 1);
            else if (mode == 8) rg = NR'($urandom);
            else                rg = '0;
            cycle(NR'($urandom), rd, rg, ($urandom_range(0, 99) == 0));
        end

        @(negedge clk);
        check_outputs();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
